// File: rtl/column_rasterizer.sv
// column_rasterizer: expands one DDA column result into SCREEN_HEIGHT frame-buffer write beats
module column_rasterizer #(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 240,
  parameter int          ADDR_W        = 17,
  parameter logic [15:0] CEIL_COLOR    = 16'h4208,
  parameter logic [15:0] FLOOR_COLOR   = 16'h8410
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              dda_fifo_tvalid_in,
  input  logic [38:0]       dda_fifo_tdata_in,
  input  logic              dda_fifo_tlast_in,
  output logic              transformer_tready_out,
  output logic [ADDR_W-1:0] ray_address_out,
  output logic [15:0]       ray_pixel_out,
  output logic              ray_valid_out,
  output logic              ray_last_pixel_out
);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [8:0] W_H = 9'(SCREEN_WIDTH);
  localparam logic [YW:0] H_F = (YW+1)'(SCREEN_HEIGHT);
  localparam logic [YW:0] MID = (YW+1)'(SCREEN_HEIGHT / 2);
  localparam logic [YW:0] MID_M1 = (YW+1)'(SCREEN_HEIGHT / 2 - 1);
  localparam logic [YW:0] BOT = (YW+1)'(SCREEN_HEIGHT - 1);
  localparam logic [YW-1:0] Y_END = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t            state_q, state_d;
  logic [8:0]        hc_q, hc_d;
  logic [7:0]        lh_q, lh_d;
  logic [3:0]        map_q, map_d;
  logic              side_q, side_d, tl_q, tl_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] acc_q, acc_d, addr_q, addr_d;
  logic [15:0]       pix_q, pix_d;
  logic              vld_q, vld_d, lp_q, lp_d, rdy_q, rdy_d;
  logic [YW:0]       half, hi, ds, de, ye;
  logic              tall, emit;
  logic [15:0]       base, wall, pix;
  logic              unused_bits;

  assign unused_bits = ^{dda_fifo_tdata_in[38], dda_fifo_tdata_in[15:0]};

  // Slice bounds and colour for the row being issued this cycle
  always_comb begin
    half = (YW+1)'(lh_q >> 1);
    hi   = MID + half;
    tall = (YW+1)'(lh_q) >= H_F;
    ds   = map_q == 4'd0 ? MID : tall ? '0 : MID - half;
    de   = map_q == 4'd0 ? MID_M1 : (tall || hi > BOT) ? BOT : hi;
    ye   = state_q == EMIT ? {1'b0, y_q} : '0;
    base = map_q == 4'd1 ? 16'hF800 : map_q == 4'd2 ? 16'h07E0 : map_q == 4'd3 ? 16'h001F :
           map_q == 4'd4 ? 16'hFFFF : 16'hFFE0;
    wall = side_q ? (base >> 1) & 16'h7BEF : base;
    pix  = ye < ds ? CEIL_COLOR : ye > de ? FLOOR_COLOR : wall;
  end

  // LOAD issues row 0 directly so the first beat lands two cycles after the handshake;
  // EMIT then runs y=1..H, with y==H as the final idle-bound cycle.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    lh_d    = lh_q;
    map_d   = map_q;
    side_d  = side_q;
    tl_d    = tl_q;
    y_d     = y_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    vld_d   = 1'b0;
    lp_d    = 1'b0;
    emit    = 1'b0;
    case (state_q)
      IDLE: if (rdy_q && dda_fifo_tvalid_in) begin
        hc_d    = dda_fifo_tdata_in[37:29];
        lh_d    = dda_fifo_tdata_in[28:21];
        side_d  = dda_fifo_tdata_in[20];
        map_d   = dda_fifo_tdata_in[19:16];
        tl_d    = dda_fifo_tlast_in;
        state_d = LOAD;
      end
      LOAD: begin
        emit    = hc_q < W_H;
        state_d = emit ? EMIT : IDLE;
      end
      EMIT: begin
        emit    = y_q != Y_END;
        state_d = emit ? EMIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      vld_d  = 1'b1;
      addr_d = state_q == LOAD ? ADDR_W'(hc_q) : acc_q;
      acc_d  = addr_d + W_A;
      pix_d  = pix;
      lp_d   = tl_q && ye == BOT;
      y_d    = ye[YW-1:0] + YW'(1);
    end
    rdy_d = state_d == IDLE;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      hc_q    <= '0;
      lh_q    <= '0;
      map_q   <= '0;
      side_q  <= 1'b0;
      tl_q    <= 1'b0;
      y_q     <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      vld_q   <= 1'b0;
      lp_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      lh_q    <= lh_d;
      map_q   <= map_d;
      side_q  <= side_d;
      tl_q    <= tl_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
      lp_q    <= lp_d;
      rdy_q   <= rdy_d;
    end
  end

  assign transformer_tready_out = rdy_q;
  assign ray_address_out        = addr_q;
  assign ray_pixel_out          = pix_q;
  assign ray_valid_out          = vld_q;
  assign ray_last_pixel_out     = lp_q;
endmodule

// File: tb/tb_column_rasterizer.sv
// tb_column_rasterizer: column-level model predicts every beat and tready per cycle
module tb_column_rasterizer;
  localparam int W = 320, H = 240, AW = 17;
  localparam logic [15:0] CEIL = 16'h4208, FLOOR = 16'h8410;

  logic clk = 1'b0, rst = 1'b1, tvalid = 1'b0, tlast = 1'b0;
  logic [38:0] tdata = '0;
  logic tready, vld, lastp;
  logic [AW-1:0] addr;
  logic [15:0] pix;

  column_rasterizer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW),
    .CEIL_COLOR(CEIL), .FLOOR_COLOR(FLOOR)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .dda_fifo_tvalid_in(tvalid),
    .dda_fifo_tdata_in(tdata), .dda_fifo_tlast_in(tlast),
    .transformer_tready_out(tready), .ray_address_out(addr), .ray_pixel_out(pix),
    .ray_valid_out(vld), .ray_last_pixel_out(lastp));

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; logic [15:0] pix; logic last;} beat_t;
  beat_t exp_q[$];
  logic [39:0] fifo[$];
  int hs_log[$];
  int cyc = 0, busy_until = 0, tests = 0, fails = 0, vcnt = 0, lcnt = 0, last_addr = -1;
  bit chk_en = 1'b0, hs_real = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int lh, input int side, input int map, input int y);
    int ds, de;
    logic [15:0] c;
    if (lh >= H) begin ds = 0; de = H - 1; end
    else begin ds = H / 2 - lh / 2; de = (H / 2 + lh / 2 > H - 1) ? H - 1 : H / 2 + lh / 2; end
    if (map == 0) begin ds = H / 2; de = H / 2 - 1; end
    c = map == 1 ? 16'hF800 : map == 2 ? 16'h07E0 : map == 3 ? 16'h001F : map == 4 ? 16'hFFFF : 16'hFFE0;
    if (side != 0) c = (c >> 1) & 16'h7BEF;
    return y < ds ? CEIL : y > de ? FLOOR : c;
  endfunction

  function automatic logic [39:0] mk(input int h, input int lh, input int side, input int map, input int last);
    return {last[0], 1'b0, h[8:0], lh[7:0], side[0], map[3:0], 16'hA5C3};
  endfunction

  // Model: one handshake becomes a whole column of predicted beats
  always @(negedge clk) begin
    beat_t b;
    int h, lh, sd, mp;
    cyc++;
    hs_real = tvalid && tready;
    if (vld) begin
      vcnt++;
      if (lastp) begin lcnt++; last_addr = int'(addr); end
    end
    if (chk_en) begin
      chk("tready", tready, cyc > busy_until);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        b = exp_q.pop_front();
        chk("beat_valid", vld, 1);
        chk("beat_addr", addr, b.addr);
        chk("beat_pix", pix, b.pix);
        chk("beat_last", lastp, b.last);
      end else chk("idle_valid", vld, 0);
      if (tvalid && cyc > busy_until) begin
        h = int'(tdata[37:29]); lh = int'(tdata[28:21]); sd = int'(tdata[20]); mp = int'(tdata[19:16]);
        hs_log.push_back(cyc);
        if (h < W) begin
          for (int y = 0; y < H; y++) begin
            b.cyc = cyc + 2 + y; b.addr = y * W + h; b.pix = exp_pix(lh, sd, mp, y);
            b.last = tlast && (y == H - 1);
            exp_q.push_back(b);
          end
          busy_until = cyc + H + 1;
        end else busy_until = cyc + 1;
      end
    end
  end

  // FIFO front end: pops on the real handshake seen at the previous sample point
  always @(posedge clk) begin
    #1;
    if (hs_real && fifo.size() > 0) void'(fifo.pop_front());
    if (fifo.size() > 0) {tlast, tdata} = fifo[0];
    tvalid = fifo.size() > 0;
  end

  task automatic wait_idle();
    int n = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0 || cyc <= busy_until) && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    chk("idle_timeout", n < 3000, 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    chk("pin_r99", exp_pix(40, 0, 1, 99), 16'h4208);
    chk("pin_r100", exp_pix(40, 0, 1, 100), 16'hF800);
    chk("pin_r140", exp_pix(40, 0, 1, 140), 16'hF800);
    chk("pin_r141", exp_pix(40, 0, 1, 141), 16'h8410);
    chk("pin_shade", exp_pix(255, 1, 2, 239), 16'h03E0);
    chk("pin_nohit119", exp_pix(200, 0, 0, 119), 16'h4208);
    chk("pin_nohit120", exp_pix(200, 0, 0, 120), 16'h8410);
    chk("pin_white_shade", exp_pix(60, 1, 4, 120), 16'h7BEF);
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_valid", vld, 0); chk("rst_addr", addr, 0); chk("rst_pix", pix, 0);
      chk("rst_last", lastp, 0); chk("rst_tready", tready, 0);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_tready", tready, 1); chk("post_rst_valid", vld, 0);
    busy_until = cyc; chk_en = 1'b1;

    vcnt = 0; lcnt = 0;
    fifo.push_back(mk(5, 40, 0, 1, 0));
    wait_idle();
    chk("t2_beats", vcnt, 240); chk("t2_last", lcnt, 0);
    chk("t2_hold_addr", addr, 76485); chk("t2_hold_pix", pix, 16'h8410);

    vcnt = 0; lcnt = 0;
    fifo.push_back(mk(319, 255, 1, 2, 1));
    wait_idle();
    chk("t3_beats", vcnt, 240); chk("t3_last", lcnt, 1); chk("t3_last_addr", last_addr, 76799);

    vcnt = 0;
    fifo.push_back(mk(77, 200, 0, 0, 0));
    wait_idle();
    chk("t4_beats", vcnt, 240);

    vcnt = 0; lcnt = 0; hs_log.delete();
    fifo.push_back(mk(10, 0, 0, 5, 0));
    fifo.push_back(mk(20, 239, 1, 4, 0));
    fifo.push_back(mk(30, 241, 0, 3, 1));
    wait_idle();
    chk("t5_beats", vcnt, 720); chk("t5_last", lcnt, 1); chk("t5_hs", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("t5_gap01", hs_log[1] - hs_log[0], 242);
      chk("t5_gap12", hs_log[2] - hs_log[1], 242);
    end

    vcnt = 0; n = 0;
    fifo.push_back(mk(7, 100, 0, 3, 1));
    while (vcnt < 58 && n < 1000) begin @(negedge clk); #1; n++; end
    chk("t6_reach_y57", vcnt, 58);
    #2 rst = 1'b1; chk_en = 1'b0;
    #1;
    chk("t6_rst_valid", vld, 0); chk("t6_rst_addr", addr, 0); chk("t6_rst_pix", pix, 0);
    chk("t6_rst_last", lastp, 0); chk("t6_rst_tready", tready, 0);
    exp_q.delete();
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_post_tready", tready, 1); chk("t6_post_valid", vld, 0);
    busy_until = cyc; chk_en = 1'b1;
    vcnt = 0; lcnt = 0;
    fifo.push_back(mk(8, 60, 1, 4, 1));
    wait_idle();
    chk("t6_next_beats", vcnt, 240); chk("t6_next_last", lcnt, 1);

    vcnt = 0; lcnt = 0;
    fifo.push_back(mk(400, 50, 0, 1, 1));
    wait_idle();
    chk("t7_drop_beats", vcnt, 0); chk("t7_drop_last", lcnt, 0); chk("t7_tready", tready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
